// File: rtl/addr_map_scheduler.sv
// rtl/addr_map_scheduler.sv - burst scheduler for the shared polynomial memory port and permutation stage
//
// Grants the 64-word memory port to one of three requesters (decode, encode,
// standard), then issues a 64-beat linear address burst with the matching
// mapping code for the downstream address-permutation stage.
//
// Optional feature macro: ADDR_MAP_RR_EN
//   undefined : fixed priority standard > decode > encode
//   defined   : round-robin starting after the last completed winner
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   req       in   [2:0] level burst request (0 decode, 1 encode, 2 standard)
//   req_we    in   [2:0] per-requester direction, 1 = write
//   mem_rdy   in   memory accepts current beat
//   gnt       out  [2:0] one-hot grant, held for the burst
//   busy      out  burst in progress
//   mapping   out  [MAP_W-1:0] mapping code (0 decode, 1 encode, 2 standard)
//   addr_raw  out  [ADDR_W-1:0] unpermuted beat address
//   addr_vld  out  beat valid
//   addr_we   out  beat is a write
//   last      out  current beat is the final one
//   done      out  [2:0] one-cycle completion pulse to the granted requester

module addr_map_scheduler #(
    parameter int ADDR_W = 6,
    parameter int MAP_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        req,
    input  logic [2:0]        req_we,
    input  logic              mem_rdy,
    output logic [2:0]        gnt,
    output logic              busy,
    output logic [MAP_W-1:0]  mapping,
    output logic [ADDR_W-1:0] addr_raw,
    output logic              addr_vld,
    output logic              addr_we,
    output logic              last,
    output logic [2:0]        done
);

    localparam logic [MAP_W-1:0]  MAP_STANDARD = MAP_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_LAST    = '1;
    localparam logic [ADDR_W-1:0] ADDR_PRELAST = ADDR_LAST - ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic [MAP_W-1:0]  mapping_q, mapping_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              vld_q, vld_d;
    logic              we_q, we_d;
    logic              last_q, last_d;
    logic [2:0]        done_q, done_d;

    // Arbiter result: requester index doubles as its mapping code.
    logic              pick_vld;
    logic [1:0]        pick_idx;

`ifdef ADDR_MAP_RR_EN
    // Index of the last requester whose burst completed.
    logic [1:0] rr_ptr_q, rr_ptr_d;

    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

    always_comb begin
        logic [1:0] cand;
        pick_vld = 1'b0;
        pick_idx = 2'd0;
        cand     = 2'd0;
        // Walk the search order backwards so the nearest candidate overrides.
        for (int k = 3; k >= 1; k--) begin
            cand = wrap3({1'b0, rr_ptr_q} + 3'(k));
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end
`else
    always_comb begin
        pick_vld = |req;
        pick_idx = 2'd0;
        if (req[2]) begin
            pick_idx = 2'd2;
        end else if (req[0]) begin
            pick_idx = 2'd0;
        end else if (req[1]) begin
            pick_idx = 2'd1;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        mapping_d = mapping_q;
        addr_d    = addr_q;
        vld_d     = vld_q;
        we_d      = we_q;
        last_d    = last_q;
        done_d    = 3'b000;
`ifdef ADDR_MAP_RR_EN
        rr_ptr_d  = rr_ptr_q;
`endif

        case (state_q)
            S_IDLE: begin
                gnt_d     = 3'b000;
                busy_d    = 1'b0;
                mapping_d = MAP_STANDARD;
                addr_d    = '0;
                vld_d     = 1'b0;
                we_d      = 1'b0;
                last_d    = 1'b0;
                if (pick_vld) begin
                    state_d   = S_BURST;
                    gnt_d     = 3'b001 << pick_idx;
                    busy_d    = 1'b1;
                    mapping_d = MAP_W'(pick_idx);
                    vld_d     = 1'b1;
                    we_d      = req_we[pick_idx];
                end
            end

            S_BURST: begin
                if ((req & gnt_q) == 3'b000) begin
                    // Requester withdrew: drop the rest of the burst silently.
                    state_d   = S_IDLE;
                    gnt_d     = 3'b000;
                    busy_d    = 1'b0;
                    mapping_d = MAP_STANDARD;
                    addr_d    = '0;
                    vld_d     = 1'b0;
                    we_d      = 1'b0;
                    last_d    = 1'b0;
                end else if (mem_rdy) begin
                    if (last_q) begin
                        state_d = S_DONE;
                        done_d  = gnt_q;
                        gnt_d   = 3'b000;
                        busy_d  = 1'b0;
                        addr_d  = '0;
                        vld_d   = 1'b0;
                        we_d    = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        last_d = (addr_q == ADDR_PRELAST);
                    end
                end
            end

            S_DONE: begin
                state_d   = S_IDLE;
                mapping_d = MAP_STANDARD;
`ifdef ADDR_MAP_RR_EN
                // Only completed bursts advance fairness; aborts never get here.
                rr_ptr_d  = mapping_q[1:0];
`endif
            end

            default: begin
                state_d   = S_IDLE;
                gnt_d     = 3'b000;
                busy_d    = 1'b0;
                mapping_d = MAP_STANDARD;
                addr_d    = '0;
                vld_d     = 1'b0;
                we_d      = 1'b0;
                last_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            gnt_q     <= 3'b000;
            busy_q    <= 1'b0;
            mapping_q <= MAP_STANDARD;
            addr_q    <= '0;
            vld_q     <= 1'b0;
            we_q      <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 3'b000;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            mapping_q <= mapping_d;
            addr_q    <= addr_d;
            vld_q     <= vld_d;
            we_q      <= we_d;
            last_q    <= last_d;
            done_q    <= done_d;
        end
    end

`ifdef ADDR_MAP_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 2'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign gnt      = gnt_q;
    assign busy     = busy_q;
    assign mapping  = mapping_q;
    assign addr_raw = addr_q;
    assign addr_vld = vld_q;
    assign addr_we  = we_q;
    assign last     = last_q;
    assign done     = done_q;

endmodule

// File: tb/tb_addr_map_scheduler.sv
// tb/tb_addr_map_scheduler.sv - directed self-checking bench for addr_map_scheduler

module tb_addr_map_scheduler;

    logic       clk;
    logic       rst_n;
    logic [2:0] req;
    logic [2:0] req_we;
    logic       mem_rdy;
    logic [2:0] gnt;
    logic       busy;
    logic [1:0] mapping;
    logic [5:0] addr_raw;
    logic       addr_vld;
    logic       addr_we;
    logic       last;
    logic [2:0] done;

    int checks = 0;
    int errors = 0;

    addr_map_scheduler #(.ADDR_W(6), .MAP_W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_we   (req_we),
        .mem_rdy  (mem_rdy),
        .gnt      (gnt),
        .busy     (busy),
        .mapping  (mapping),
        .addr_raw (addr_raw),
        .addr_vld (addr_vld),
        .addr_we  (addr_we),
        .last     (last),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_vld"}, 32'(addr_vld), 32'h0);
        chk({tag, "_addr"}, 32'(addr_raw), 32'h0);
        chk({tag, "_map"}, 32'(mapping), 32'h2);
        chk({tag, "_we"}, 32'(addr_we), 32'h0);
        chk({tag, "_last"}, 32'(last), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
    endtask

    logic [2:0] ord3 [3];
    logic [1:0] map3 [3];
    logic [2:0] ord6 [6];
    int xfers;

    initial begin
        rst_n   = 1'b0;
        req     = 3'b000;
        req_we  = 3'b000;
        mem_rdy = 1'b1;
        tick();
        chk_idle("reset");

        // Single decode read, continuous mem_rdy.
        rst_n = 1'b1;
        req   = 3'b001;
        tick();
        chk("dec_gnt", 32'(gnt), 32'h1);
        chk("dec_busy", 32'(busy), 32'h1);
        chk("dec_map", 32'(mapping), 32'h0);
        chk("dec_we", 32'(addr_we), 32'h0);
        for (int b = 0; b < 64; b++) begin
            chk("dec_addr", 32'(addr_raw), 32'(b));
            chk("dec_vld", 32'(addr_vld), 32'h1);
            chk("dec_last", 32'(last), (b == 63) ? 32'h1 : 32'h0);
            chk("dec_nodone", 32'(done), 32'h0);
            tick();
        end
        chk("dec_done", 32'(done), 32'h1);
        chk("dec_done_gnt", 32'(gnt), 32'h0);
        chk("dec_done_vld", 32'(addr_vld), 32'h0);
        chk("dec_done_busy", 32'(busy), 32'h0);
        chk("dec_done_last", 32'(last), 32'h0);
        req = 3'b000;
        tick();
        chk_idle("dec_after");

        // Encode write with alternating stalls; req_we change mid-burst ignored.
        req    = 3'b010;
        req_we = 3'b010;
        tick();
        chk("enc_gnt", 32'(gnt), 32'h2);
        xfers = 0;
        for (int c = 0; c < 128; c++) begin
            mem_rdy = c[0];
            if (c == 50) req_we = 3'b000;
            chk("enc_addr", 32'(addr_raw), 32'(c / 2));
            chk("enc_map", 32'(mapping), 32'h1);
            chk("enc_we", 32'(addr_we), 32'h1);
            chk("enc_busy", 32'(busy), 32'h1);
            if (addr_vld && mem_rdy) xfers++;
            tick();
        end
        chk("enc_xfers", 32'(xfers), 32'd64);
        chk("enc_done", 32'(done), 32'h2);
        req     = 3'b000;
        req_we  = 3'b000;
        mem_rdy = 1'b1;
        tick();
        chk_idle("enc_after");

        // All three request at once; losers wait.
        ord3[0] = 3'b100; ord3[1] = 3'b001; ord3[2] = 3'b010;
        map3[0] = 2'd2;   map3[1] = 2'd0;   map3[2] = 2'd1;
        req = 3'b111;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("all_gnt", 32'(gnt), 32'(ord3[k]));
            chk("all_map", 32'(mapping), 32'(map3[k]));
            repeat (64) tick();
            chk("all_done", 32'(done), 32'(ord3[k]));
            req = req & ~ord3[k];
            tick();
            chk("all_gap_gnt", 32'(gnt), 32'h0);
            chk("all_gap_done", 32'(done), 32'h0);
        end

        // Six bursts with every request held, starting from reset state.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
`ifdef ADDR_MAP_RR_EN
        ord6[0] = 3'b010; ord6[1] = 3'b100; ord6[2] = 3'b001;
        ord6[3] = 3'b010; ord6[4] = 3'b100; ord6[5] = 3'b001;
`else
        ord6[0] = 3'b100; ord6[1] = 3'b100; ord6[2] = 3'b100;
        ord6[3] = 3'b100; ord6[4] = 3'b100; ord6[5] = 3'b100;
`endif
        req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("six_gnt", 32'(gnt), 32'(ord6[k]));
            repeat (64) tick();
            chk("six_done", 32'(done), 32'(ord6[k]));
            if (k == 5) req = 3'b000;
            tick();
            chk("six_gap_gnt", 32'(gnt), 32'h0);
        end

        // Abort decode at beat 20, then a fresh encode burst starts at 0.
        req = 3'b001;
        tick();
        repeat (20) tick();
        chk("abt_addr20", 32'(addr_raw), 32'd20);
        req = 3'b000;
        tick();
        chk_idle("abt");
        tick();
        chk("abt_nodone", 32'(done), 32'h0);
        req = 3'b010;
        tick();
        chk("abt_next_gnt", 32'(gnt), 32'h2);
        chk("abt_next_addr", 32'(addr_raw), 32'h0);
        chk("abt_next_vld", 32'(addr_vld), 32'h1);
        req = 3'b000;
        tick();
        chk_idle("abt2");

        // Asynchronous reset at beat 40 of a standard burst.
        req = 3'b100;
        tick();
        repeat (40) tick();
        chk("rst_addr40", 32'(addr_raw), 32'd40);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("arst");
        tick();
        tick();
        chk("arst_nodone", 32'(done), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("arst_regnt", 32'(gnt), 32'h4);
        chk("arst_addr", 32'(addr_raw), 32'h0);
        chk("arst_map", 32'(mapping), 32'h2);
        req = 3'b000;
        tick();
        chk_idle("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
